mpu_ctrl_fsm: RTL and testbench
===============================

# mpu_ctrl_fsm

Parametrised control sequencer for the Matrix Processing Unit. It replaces the fixed 4-bank, single-cycle controller with a generalised version: the bank count and the data/beat widths are parameters, host instructions use a valid/ready handshake, and arithmetic ops start a functional unit and wait for its `done` before writeback. It sits between the host instruction port and the BRAM bank array, the operand/destination muxes and the four functional units (adder, shifter, subtractor, multiplier).

## Interface
- `BANK_W`, 2: bank index width; `NUM_BANKS = 2**BANK_W`.
- `DATA_W`, 512: bank word width in bits.
- `BEAT_W`, 8: host load/unload beat width; `BEATS = DATA_W/BEAT_W` (64). `DATA_W` must be a multiple of `BEAT_W`.
- `TIMEOUT_CYCLES`, 1024: wait limit. Used only with `MPU_CTRL_TIMEOUT_EN`.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `instr`  in  `4+2*BANK_W`  instruction: `[3:0]` opcode, `[4+:BANK_W]` src (AA), `[4+BANK_W+:BANK_W]` dst (DD).
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  controller can accept an instruction.
- `unit_done`  in  4  done flags, one per unit: [0] add, [1] shift, [2] sub, [3] mult.
- `unit_start`  out  4  one-cycle start pulse, one per unit, same order.
- `bank_we`  out  `NUM_BANKS`  full-word write enable.
- `bank_we1`  out  `NUM_BANKS`  single-beat write enable.
- `bank_rst`  out  `NUM_BANKS`  bank clear.
- `src_sel`, `dst_sel`  out  `BANK_W`  latched src/dst bank indices.
- `out_sel`  out  2  result mux select (unit index).
- `bram_in_sel`  out  1  1 = bank-to-bank copy path.
- `offset`  out  `$clog2(DATA_W)`  bit offset of the current beat.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  timeout pulse.

## Operation
- Outputs are Moore decodes of the state register plus the instruction latch.
- Handshake: an instruction is accepted when `instr_valid && instr_ready`. `instr_ready` = (state == IDLE). On accept, `instr` is latched and is not sampled again until the next accept.
- States: RST, IDLE, START, WAIT, WB, LOAD, UNLOAD, COPY, CLEAR, ABORT.
- RST:
  - Entered while `reset` is high, and from any illegal state encoding.
  - Outputs: `bank_rst` all ones, `busy`=1, `instr_ready`=0, `offset`=`BEAT_W-1`, all other outputs 0.
  - Moves to IDLE on the first clock after `reset` falls.
- Opcode decode on accept:
  - 0100 → LOAD; 0110 → UNLOAD; 0101 → COPY; 0111 → CLEAR.
  - 1100 add, 1101 shift, 1110 sub, 1111 mult → START. The unit index is k = opcode[1:0].
  - 00xx and 10xx are NOPs: the instruction is accepted and the controller stays in IDLE.
- START: `unit_start[k]`=1 for one cycle → WAIT.
- WAIT:
  - `unit_done[k]` is sampled here only.
  - On 1 → WB.
  - `done` bits of other units, and any `done` arriving outside WAIT, are ignored.
- WB: `bank_we[dst]`=1 and `out_sel`=k for one cycle → IDLE.
- LOAD:
  - Lasts `BEATS` cycles. Beat i (0..BEATS-1) asserts `bank_we1[dst]` with `offset` = `BEAT_W-1 + i*BEAT_W` (7, 15, …, 511).
  - Returns to IDLE after the last beat.
- UNLOAD: same beat/offset sequence as LOAD with no write enables; `dst_sel` selects the host output bank.
- COPY:
  - One cycle: `bank_we[dst]`=1, `bram_in_sel`=1, `src_sel`=src → IDLE.
  - src == dst is legal and still writes.
- CLEAR: one cycle, `bank_rst[dst]`=1 → IDLE.
- Only one bit of each enable vector may be high in any cycle. The exception is RST, where all `bank_rst` bits are high.
- Reset mid-operation aborts immediately: no further enables are issued and the beat counter is cleared.

## Timing
- Accept at cycle T.
- Single-cycle ops (COPY, CLEAR) act at T+1; `instr_ready` is high again at T+2.
- LOAD/UNLOAD act from T+1 to T+BEATS; `instr_ready` returns at T+BEATS+1.
- Arithmetic ops:
  - Start pulse at T+1; WAIT begins at T+2.
  - `unit_done` first seen at cycle D ≥ T+2 → WB at D+1, `instr_ready` at D+2.
  - Minimum arithmetic latency is 4 cycles from accept to ready.
- `offset` holds `BEAT_W-1` in every state other than LOAD and UNLOAD.

## Configuration
- `MPU_CTRL_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs. If `unit_done[k]` has not been seen by the `TIMEOUT_CYCLES`-th WAIT cycle, the controller goes to ABORT.
  - ABORT: `err`=1 for one cycle, `busy`=1, no writeback → IDLE.
  - If `done` arrives in the expiry cycle, `done` wins and the controller goes to WB.
- `MPU_CTRL_TIMEOUT_EN` not defined: WAIT is unbounded, `err` is tied to 0, and ABORT is unreachable.

## Test plan
- Reset, then release → one RST cycle with `bank_rst`=4'b1111, then IDLE with `instr_ready`=1, `busy`=0, `offset`=7.
- LOAD with dst=2 (`instr`=8'b10_00_0100) → 64 cycles of `bank_we1`=4'b0100 with `offset` 7, 15, …, 511, then IDLE; `bank_we` stays 0.
- MULT with src=1, dst=3, `unit_done[3]` raised 5 cycles after the start pulse → `unit_start`=4'b1000 for exactly one cycle, then one WB cycle with `bank_we`=4'b1000 and `out_sel`=3. `unit_done[0]` pulsed during WAIT has no effect.
- COPY src=0 → dst=1, then CLEAR dst=1 issued back-to-back with `instr_valid` held high → COPY cycle (`bank_we`=4'b0010, `bram_in_sel`=1), one IDLE cycle, CLEAR cycle (`bank_rst`=4'b0010).
- Reset asserted at LOAD beat 10 → enables drop immediately; after release the controller reaches IDLE with `offset`=7.
- With `MPU_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, ADD with `unit_done` never raised → `err` pulses for one cycle after 16 WAIT cycles, no `bank_we`, then `instr_ready`=1.

Source files
------------

// File: rtl/mpu_ctrl_fsm.sv
// mpu_ctrl_fsm: control sequencer for the Matrix Processing Unit.
// Accepts host instructions through a valid/ready handshake and sequences the
// BRAM bank array, the operand/destination muxes and the four functional units.
//
// Optional feature macro: MPU_CTRL_TIMEOUT_EN. When it is defined, WAIT is
// bounded by TIMEOUT_CYCLES and an expired wait goes through ABORT (err pulse).
// When it is undefined, WAIT is unbounded and err is tied to 0.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   instr            [3:0] opcode, [4+:BANK_W] src, [4+BANK_W+:BANK_W] dst
//   instr_valid      instruction present
//   instr_ready      controller idle and able to accept
//   unit_done        done flags {mult, sub, shift, add}
//   unit_start       one-cycle start pulse per unit, same order
//   bank_we          full-word write enable per bank
//   bank_we1         single-beat write enable per bank
//   bank_rst         bank clear per bank
//   src_sel/dst_sel  latched src/dst bank indices
//   out_sel          result mux select (unit index)
//   bram_in_sel      1 selects the bank-to-bank copy path
//   offset           bit offset of the current beat
//   busy             high outside IDLE
//   err              one-cycle timeout pulse
module mpu_ctrl_fsm #(
  parameter int unsigned BANK_W         = 2,
  parameter int unsigned DATA_W         = 512,
  parameter int unsigned BEAT_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [4+2*BANK_W-1:0]       instr,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [3:0]                  unit_done,
  output logic [3:0]                  unit_start,
  output logic [(1<<BANK_W)-1:0]      bank_we,
  output logic [(1<<BANK_W)-1:0]      bank_we1,
  output logic [(1<<BANK_W)-1:0]      bank_rst,
  output logic [BANK_W-1:0]           src_sel,
  output logic [BANK_W-1:0]           dst_sel,
  output logic [1:0]                  out_sel,
  output logic                        bram_in_sel,
  output logic [$clog2(DATA_W)-1:0]   offset,
  output logic                        busy,
  output logic                        err
);

  localparam int unsigned NUM_BANKS = 1 << BANK_W;
  localparam int unsigned BEATS     = DATA_W / BEAT_W;
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W     = $clog2(DATA_W);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_IDLE   = 4'd1,
    S_START  = 4'd2,
    S_WAIT   = 4'd3,
    S_WB     = 4'd4,
    S_LOAD   = 4'd5,
    S_UNLOAD = 4'd6,
    S_COPY   = 4'd7,
    S_CLEAR  = 4'd8,
    S_ABORT  = 4'd9
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [BANK_W-1:0]  src_q;
  logic [BANK_W-1:0]  dst_q;
  logic [1:0]         unit_q;
  logic [CNT_W-1:0]   beat_q;
  logic               beat_last;
  logic               accept;

  assign accept    = (state_q == S_IDLE) && instr_valid;
  assign beat_last = (beat_q == CNT_W'(BEATS - 1));

`ifdef MPU_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] wait_cnt_q;
  logic            wait_expired;

  // wait_cnt_q counts WAIT cycles already spent; expiry is the TIMEOUT_CYCLES-th one.
  assign wait_expired = (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  wait_cnt_q <= '0;
    else if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + TO_W'(1);
    else                        wait_cnt_q <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  // Instruction latch: sampled only on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      unit_q <= '0;
    end else if (accept) begin
      src_q  <= instr[4+:BANK_W];
      dst_q  <= instr[4+BANK_W+:BANK_W];
      unit_q <= instr[1:0];
    end
  end

  // Beat counter for LOAD/UNLOAD; zero everywhere else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      beat_q <= '0;
    else if ((state_q == S_LOAD || state_q == S_UNLOAD) && !beat_last)
      beat_q <= beat_q + CNT_W'(1);
    else
      beat_q <= '0;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   state_d = S_IDLE;
      S_IDLE: begin
        if (instr_valid) begin
          casez (instr[3:0])
            4'b0100: state_d = S_LOAD;
            4'b0110: state_d = S_UNLOAD;
            4'b0101: state_d = S_COPY;
            4'b0111: state_d = S_CLEAR;
            4'b11??: state_d = S_START;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (unit_done[unit_q]) state_d = S_WB;
`ifdef MPU_CTRL_TIMEOUT_EN
        else if (wait_expired) state_d = S_ABORT;
`endif
      end
      S_WB:     state_d = S_IDLE;
      S_LOAD:   if (beat_last) state_d = S_IDLE;
      S_UNLOAD: if (beat_last) state_d = S_IDLE;
      S_COPY:   state_d = S_IDLE;
      S_CLEAR:  state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_RST;
    endcase
  end

  // Moore output decode from state and instruction latch.
  always_comb begin
    instr_ready = 1'b0;
    unit_start  = '0;
    bank_we     = '0;
    bank_we1    = '0;
    bank_rst    = '0;
    src_sel     = src_q;
    dst_sel     = dst_q;
    out_sel     = 2'd0;
    bram_in_sel = 1'b0;
    offset      = OFF_W'(BEAT_W - 1);
    busy        = 1'b1;
    err         = 1'b0;
    case (state_q)
      S_RST: begin
        bank_rst = {NUM_BANKS{1'b1}};
        src_sel  = '0;
        dst_sel  = '0;
      end
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      S_START: unit_start[unit_q] = 1'b1;
      S_WB: begin
        bank_we[dst_q] = 1'b1;
        out_sel        = unit_q;
      end
      S_LOAD: begin
        bank_we1[dst_q] = 1'b1;
        offset          = OFF_W'(BEAT_W - 1) + OFF_W'(beat_q) * OFF_W'(BEAT_W);
      end
      S_UNLOAD: offset = OFF_W'(BEAT_W - 1) + OFF_W'(beat_q) * OFF_W'(BEAT_W);
      S_COPY: begin
        bank_we[dst_q] = 1'b1;
        bram_in_sel    = 1'b1;
      end
      S_CLEAR: bank_rst[dst_q] = 1'b1;
      S_ABORT: begin
`ifdef MPU_CTRL_TIMEOUT_EN
        err = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mpu_ctrl_fsm.sv
// Directed testbench for mpu_ctrl_fsm (BANK_W=2, DATA_W=512, BEAT_W=8,
// TIMEOUT_CYCLES=16). Inputs change and outputs are checked on the falling edge.
module tb_mpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] unit_done;
  logic [3:0] unit_start;
  logic [3:0] bank_we;
  logic [3:0] bank_we1;
  logic [3:0] bank_rst;
  logic [1:0] src_sel;
  logic [1:0] dst_sel;
  logic [1:0] out_sel;
  logic       bram_in_sel;
  logic [8:0] offset;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mpu_ctrl_fsm #(
    .BANK_W(2), .DATA_W(512), .BEAT_W(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .unit_done(unit_done), .unit_start(unit_start),
    .bank_we(bank_we), .bank_we1(bank_we1), .bank_rst(bank_rst),
    .src_sel(src_sel), .dst_sel(dst_sel), .out_sel(out_sel),
    .bram_in_sel(bram_in_sel), .offset(offset), .busy(busy), .err(err)
  );

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (bank_rst !== 4'b1111) begin n_fail++; $display("FAIL rst_bank_rst: got %b expected 1111", bank_rst); end
    n_checks++; if (busy !== 1'b1 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_busy_ready: got %b%b expected 10", busy, instr_ready); end
    n_checks++; if (offset !== 9'd7) begin n_fail++; $display("FAIL rst_offset: got %0d expected 7", offset); end
    reset = 1'b0;
    #1;
    n_checks++; if (bank_rst !== 4'b1111 || bank_we !== 4'b0) begin n_fail++; $display("FAIL rst_release_cycle: got rst=%b we=%b expected 1111/0000", bank_rst, bank_we); end
    @(negedge clk);
    n_checks++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_ready_busy: got %b%b expected 10", instr_ready, busy); end
    n_checks++; if (offset !== 9'd7 || bank_rst !== 4'b0) begin n_fail++; $display("FAIL idle_offset_rst: got %0d/%b expected 7/0000", offset, bank_rst); end
  endtask

  task automatic test_load();
    instr = 8'b10_00_0100; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      n_checks++; if (bank_we1 !== 4'b0100) begin n_fail++; $display("FAIL load_we1 beat %0d: got %b expected 0100", i, bank_we1); end
      n_checks++; if (offset !== 9'(7 + 8*i)) begin n_fail++; $display("FAIL load_offset beat %0d: got %0d expected %0d", i, offset, 7 + 8*i); end
      n_checks++; if (bank_we !== 4'b0 || instr_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL load_misc beat %0d: got we=%b rdy=%b busy=%b expected 0000/0/1", i, bank_we, instr_ready, busy); end
      @(negedge clk);
    end
    n_checks++; if (instr_ready !== 1'b1 || bank_we1 !== 4'b0 || offset !== 9'd7) begin n_fail++; $display("FAIL load_end: got rdy=%b we1=%b off=%0d expected 1/0000/7", instr_ready, bank_we1, offset); end
  endtask

  task automatic test_unload();
    instr = 8'b11_00_0110; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      n_checks++; if (bank_we1 !== 4'b0 || bank_we !== 4'b0 || bank_rst !== 4'b0) begin n_fail++; $display("FAIL unload_enables beat %0d: got %b/%b/%b expected all 0", i, bank_we1, bank_we, bank_rst); end
      n_checks++; if (offset !== 9'(7 + 8*i) || dst_sel !== 2'd3) begin n_fail++; $display("FAIL unload_offset beat %0d: got %0d/%0d expected %0d/3", i, offset, dst_sel, 7 + 8*i); end
      @(negedge clk);
    end
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL unload_end: got rdy=%b expected 1", instr_ready); end
  endtask

  task automatic test_nop();
    instr = 8'b11_11_1000; instr_valid = 1'b1;
    @(negedge clk);
    instr = 8'b11_11_0010;
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++; if (instr_ready !== 1'b1 || busy !== 1'b0 || bank_we !== 4'b0 || unit_start !== 4'b0) begin n_fail++; $display("FAIL nop_stays_idle: got rdy=%b busy=%b we=%b st=%b expected 1/0/0000/0000", instr_ready, busy, bank_we, unit_start); end
  endtask

  task automatic test_mult();
    instr = 8'b11_01_1111; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++; if (unit_start !== 4'b1000) begin n_fail++; $display("FAIL mult_start: got %b expected 1000", unit_start); end
    n_checks++; if (src_sel !== 2'd1 || dst_sel !== 2'd3) begin n_fail++; $display("FAIL mult_sel: got %0d/%0d expected 1/3", src_sel, dst_sel); end
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      n_checks++; if (unit_start !== 4'b0 || bank_we !== 4'b0 || busy !== 1'b1 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL mult_wait %0d: got st=%b we=%b busy=%b rdy=%b expected 0000/0000/1/0", j, unit_start, bank_we, busy, instr_ready); end
      unit_done = (j == 2) ? 4'b0001 : (j == 5) ? 4'b1000 : 4'b0000;
    end
    @(negedge clk);
    unit_done = 4'b0;
    n_checks++; if (bank_we !== 4'b1000 || out_sel !== 2'd3) begin n_fail++; $display("FAIL mult_wb: got we=%b out_sel=%0d expected 1000/3", bank_we, out_sel); end
    n_checks++; if (bram_in_sel !== 1'b0 || unit_start !== 4'b0) begin n_fail++; $display("FAIL mult_wb_misc: got bis=%b st=%b expected 0/0000", bram_in_sel, unit_start); end
    unit_done = 4'b1000;
    @(negedge clk);
    n_checks++; if (instr_ready !== 1'b1 || bank_we !== 4'b0 || out_sel !== 2'd0) begin n_fail++; $display("FAIL mult_idle: got rdy=%b we=%b out_sel=%0d expected 1/0000/0", instr_ready, bank_we, out_sel); end
    @(negedge clk);
    unit_done = 4'b0;
    n_checks++; if (instr_ready !== 1'b1 || bank_we !== 4'b0) begin n_fail++; $display("FAIL stray_done_idle: got rdy=%b we=%b expected 1/0000", instr_ready, bank_we); end
  endtask

  task automatic test_back_to_back();
    instr = 8'b01_00_0101; instr_valid = 1'b1;
    @(negedge clk);
    instr = 8'b01_00_0111;
    n_checks++; if (bank_we !== 4'b0010 || bram_in_sel !== 1'b1) begin n_fail++; $display("FAIL copy_cycle: got we=%b bis=%b expected 0010/1", bank_we, bram_in_sel); end
    n_checks++; if (src_sel !== 2'd0 || dst_sel !== 2'd1 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL copy_sel: got %0d/%0d rdy=%b expected 0/1/0", src_sel, dst_sel, instr_ready); end
    @(negedge clk);
    n_checks++; if (instr_ready !== 1'b1 || bank_we !== 4'b0 || bank_rst !== 4'b0) begin n_fail++; $display("FAIL b2b_idle: got rdy=%b we=%b rst=%b expected 1/0000/0000", instr_ready, bank_we, bank_rst); end
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++; if (bank_rst !== 4'b0010 || bank_we !== 4'b0 || bram_in_sel !== 1'b0) begin n_fail++; $display("FAIL clear_cycle: got rst=%b we=%b bis=%b expected 0010/0000/0", bank_rst, bank_we, bram_in_sel); end
    @(negedge clk);
    n_checks++; if (instr_ready !== 1'b1 || bank_rst !== 4'b0) begin n_fail++; $display("FAIL clear_end: got rdy=%b rst=%b expected 1/0000", instr_ready, bank_rst); end
    instr = 8'b10_10_0101; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++; if (bank_we !== 4'b0100 || src_sel !== 2'd2 || bram_in_sel !== 1'b1) begin n_fail++; $display("FAIL copy_self: got we=%b src=%0d bis=%b expected 0100/2/1", bank_we, src_sel, bram_in_sel); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    instr = 8'b00_00_0100; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (offset !== 9'd87 || bank_we1 !== 4'b0001) begin n_fail++; $display("FAIL midload_beat10: got off=%0d we1=%b expected 87/0001", offset, bank_we1); end
    reset = 1'b1;
    #1;
    n_checks++; if (bank_we1 !== 4'b0 || bank_rst !== 4'b1111 || offset !== 9'd7) begin n_fail++; $display("FAIL midload_abort: got we1=%b rst=%b off=%0d expected 0000/1111/7", bank_we1, bank_rst, offset); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (instr_ready !== 1'b1 || offset !== 9'd7 || bank_we1 !== 4'b0) begin n_fail++; $display("FAIL midload_idle: got rdy=%b off=%0d we1=%b expected 1/7/0000", instr_ready, offset, bank_we1); end
    instr = 8'b01_00_0100; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++; if (offset !== 9'd7 || bank_we1 !== 4'b0010) begin n_fail++; $display("FAIL reload_beat0: got off=%0d we1=%b expected 7/0010", offset, bank_we1); end
    repeat (64) @(negedge clk);
  endtask

  task automatic test_timeout();
    instr = 8'b00_00_1100; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++; if (unit_start !== 4'b0001) begin n_fail++; $display("FAIL add_start: got %b expected 0001", unit_start); end
`ifdef MPU_CTRL_TIMEOUT_EN
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      n_checks++; if (err !== 1'b0 || busy !== 1'b1 || bank_we !== 4'b0) begin n_fail++; $display("FAIL to_wait %0d: got err=%b busy=%b we=%b expected 0/1/0000", j, err, busy, bank_we); end
    end
    @(negedge clk);
    n_checks++; if (err !== 1'b1 || bank_we !== 4'b0 || busy !== 1'b1 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL to_abort: got err=%b we=%b busy=%b rdy=%b expected 1/0000/1/0", err, bank_we, busy, instr_ready); end
    @(negedge clk);
    n_checks++; if (err !== 1'b0 || instr_ready !== 1'b1 || bank_we !== 4'b0) begin n_fail++; $display("FAIL to_idle: got err=%b rdy=%b we=%b expected 0/1/0000", err, instr_ready, bank_we); end
    instr = 8'b00_00_1100; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j == 16) unit_done = 4'b0001;
    end
    @(negedge clk);
    unit_done = 4'b0;
    n_checks++; if (bank_we !== 4'b0001 || err !== 1'b0 || out_sel !== 2'd0) begin n_fail++; $display("FAIL to_done_wins: got we=%b err=%b out_sel=%0d expected 0001/0/0", bank_we, err, out_sel); end
`else
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      n_checks++; if (err !== 1'b0 || busy !== 1'b1 || bank_we !== 4'b0) begin n_fail++; $display("FAIL nto_wait %0d: got err=%b busy=%b we=%b expected 0/1/0000", j, err, busy, bank_we); end
    end
    unit_done = 4'b0001;
    @(negedge clk);
    unit_done = 4'b0;
    n_checks++; if (bank_we !== 4'b0001 || err !== 1'b0) begin n_fail++; $display("FAIL nto_wb: got we=%b err=%b expected 0001/0", bank_we, err); end
`endif
    @(negedge clk);
    n_checks++; if (instr_ready !== 1'b1 || bank_we !== 4'b0) begin n_fail++; $display("FAIL add_end: got rdy=%b we=%b expected 1/0000", instr_ready, bank_we); end
  endtask

  initial begin
    reset       = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    unit_done   = '0;
    test_reset();
    test_load();
    test_unload();
    test_nop();
    test_mult();
    test_back_to_back();
    test_reset_mid_load();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
